sr_excitation_gen: RTL and testbench

//  Drive side of the SR flip-flop interface: turns a stream of desired Q values

---
 rtl/sr_exc_pkg.sv | 20 ++
 rtl/sr_excitation_gen_if.sv | 11 +
 rtl/sr_exc_fifo.sv | 65 ++++++
 rtl/sr_excitation_gen.sv | 118 +++++++++++
 tb/tb_sr_excitation_gen.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sr_exc_pkg.sv
// Shared SR excitation codes and the target/current -> S/R excitation function.
package sr_exc_pkg;

    localparam int unsigned DEPTH_DEF = 8;
    localparam int unsigned CNT_W_DEF = 8;

    localparam logic [1:0] SR_HOLD    = 2'b00;
    localparam logic [1:0] SR_RST     = 2'b01;
    localparam logic [1:0] SR_SET     = 2'b10;
    localparam logic [1:0] SR_ILLEGAL = 2'b11;

    // Minimal-change excitation: only drive S or R when Q must move.
    function automatic logic [1:0] sr_code(input logic target, input logic current);
        if (target == current) begin
            return SR_HOLD;
        end
        return target ? SR_SET : SR_RST;
    endfunction

endpackage

// File: rtl/sr_excitation_gen_if.sv
// Target-stream handshake between a producer of desired Q values and the excitation generator.
interface sr_excitation_gen_if;

    logic tgt_valid;
    logic tgt_bit;
    logic tgt_ready;

    modport master (output tgt_valid, output tgt_bit, input tgt_ready);
    modport slave  (input tgt_valid, input tgt_bit, output tgt_ready);

endinterface

// File: rtl/sr_exc_fifo.sv
// DEPTH x 1-bit target FIFO, falling-edge clocked, asynchronous active-high clear.
module sr_exc_fifo
    import sr_exc_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         clear,
    input  logic                         push,
    input  logic                         din,
    input  logic                         pop,
    output logic                         dout,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem_q,    mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q,  level_d;

    assign dout  = mem_q[rd_ptr_q];
    assign level = level_q;
    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = PTR_W'(wr_ptr_q + 1'b1);
        end
        if (pop) begin
            rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
        end
        case ({push, pop})
            2'b10:   level_d = LVL_W'(level_q + 1'b1);
            2'b01:   level_d = LVL_W'(level_q - 1'b1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(negedge clk or posedge clear) begin
        if (clear) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/sr_excitation_gen.sv
// SR flip-flop drive side: buffers desired Q values and emits legal S/R codes on falling edges.
// Optional Q-feedback checker enabled by defining SR_EXC_CHECK_EN.
module sr_excitation_gen
    import sr_exc_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                       clk,
    input  logic                       clear,
    sr_excitation_gen_if.slave         tgt,
    input  logic                       drive_en,
    output logic                       S,
    output logic                       R,
    output logic                       exc_valid,
    output logic                       shadow_q,
    output logic [$clog2(DEPTH+1)-1:0] level,
    input  logic                       q_fb,
    output logic                       err,
    output logic [CNT_W-1:0]           err_cnt
);

    logic       full, empty, fifo_dout;
    logic       push_c, pop_c;
    logic [1:0] sr_q, sr_d;
    logic       exc_valid_q, exc_valid_d;
    logic       shadow_d;

    assign tgt.tgt_ready = !full;
    assign push_c        = tgt.tgt_valid && !full;
    assign pop_c         = drive_en && !empty;

    sr_exc_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .clear (clear),
        .push  (push_c),
        .din   (tgt.tgt_bit),
        .pop   (pop_c),
        .dout  (fifo_dout),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        sr_d        = SR_HOLD;
        exc_valid_d = 1'b0;
        shadow_d    = shadow_q;
        if (pop_c) begin
            sr_d        = sr_code(fifo_dout, shadow_q);
            exc_valid_d = 1'b1;
            shadow_d    = fifo_dout;
        end
        // Structural guard: the forbidden code can never reach the flop.
        if (sr_d == SR_ILLEGAL) begin
            sr_d = SR_HOLD;
        end
    end

    always_ff @(negedge clk or posedge clear) begin
        if (clear) begin
            sr_q        <= SR_HOLD;
            exc_valid_q <= 1'b0;
            shadow_q    <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            exc_valid_q <= exc_valid_d;
            shadow_q    <= shadow_d;
        end
    end

    assign S         = sr_q[1];
    assign R         = sr_q[0];
    assign exc_valid = exc_valid_q;

`ifdef SR_EXC_CHECK_EN
    logic             chk_q, chk_d;
    logic [1:0]       arm_q, arm_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             mismatch_c;

    // chk_q lags shadow_q by one edge, lining up with when the FF's Q actually moves.
    always_comb begin
        chk_d      = shadow_q;
        arm_d      = (arm_q == 2'd2) ? arm_q : 2'(arm_q + 1'b1);
        mismatch_c = (arm_q == 2'd2) && (q_fb != chk_q);
        err_d      = err_q || mismatch_c;
        err_cnt_d  = err_cnt_q;
        if (mismatch_c && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = CNT_W'(err_cnt_q + 1'b1);
        end
    end

    always_ff @(negedge clk or posedge clear) begin
        if (clear) begin
            chk_q     <= 1'b0;
            arm_q     <= 2'd0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            chk_q     <= chk_d;
            arm_q     <= arm_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err     = err_q;
    assign err_cnt = err_cnt_q;
`else
    logic unused_q_fb;
    assign unused_q_fb = q_fb;
    assign err         = 1'b0;
    assign err_cnt     = '0;
`endif

endmodule

// File: tb/tb_sr_excitation_gen.sv
// Self-checking bench for sr_excitation_gen: vector table plus a queue scoreboard of targets.
module tb_sr_excitation_gen;

    localparam int unsigned DEPTH = 8;
`ifdef SR_EXC_CHECK_EN
    localparam int unsigned TB_CNT_W = 2;
`else
    localparam int unsigned TB_CNT_W = 8;
`endif

    logic                clk = 1'b0;
    logic                clear;
    logic                drive_en;
    logic                q_fb;
    logic                S, R, exc_valid, shadow_q, err;
    logic [3:0]          level;
    logic [TB_CNT_W-1:0] err_cnt;

    sr_excitation_gen_if tif ();

    sr_excitation_gen #(.DEPTH(DEPTH), .CNT_W(TB_CNT_W)) dut (
        .clk       (clk),
        .clear     (clear),
        .tgt       (tif),
        .drive_en  (drive_en),
        .S         (S),
        .R         (R),
        .exc_valid (exc_valid),
        .shadow_q  (shadow_q),
        .level     (level),
        .q_fb      (q_fb),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Feedback source: a behavioural SR flip-flop, optionally inverted, or random noise.
`ifdef SR_EXC_CHECK_EN
    logic ff_q;
    logic inv = 1'b0;
    always @(negedge clk or posedge clear) begin
        if (clear)          ff_q <= 1'b0;
        else if (S && !R)   ff_q <= 1'b1;
        else if (R && !S)   ff_q <= 1'b0;
    end
    always_comb q_fb = ff_q ^ inv;
`else
    initial q_fb = 1'b0;
    always @(posedge clk) q_fb <= 1'($urandom_range(0, 1));
`endif

    // Scoreboard: accepted targets queue up, each excitation pops and checks one.
    bit exp_q[$];
    bit model_sh   = 1'b0;
    bit pend_push  = 1'b0;
    bit pend_bit   = 1'b0;
    bit pend_pop   = 1'b0;
    int n_pops     = 0;

    always @(posedge clk) begin
        pend_push = !clear && tif.tgt_valid && (exp_q.size() < DEPTH);
        pend_bit  = tif.tgt_bit;
        pend_pop  = !clear && drive_en && (exp_q.size() > 0);
    end

    always @(negedge clk) begin
        bit         t;
        logic [1:0] exp_sr;
        #1;
        if (clear) begin
            exp_q.delete();
            model_sh = 1'b0;
        end else begin
            if (pend_pop) begin
                t        = exp_q.pop_front();
                exp_sr   = (t == model_sh) ? 2'b00 : (t ? 2'b10 : 2'b01);
                model_sh = t;
                n_pops++;
                check("sb_exc_valid", exc_valid, 1);
                check("sb_sr", {S, R}, exp_sr);
            end else begin
                check("sb_exc_idle", exc_valid, 0);
                check("sb_sr_idle", {S, R}, 0);
            end
            check("sb_shadow", shadow_q, model_sh);
            if (pend_push) exp_q.push_back(pend_bit);
            check("sb_level", level, exp_q.size());
            check("sb_ready", tif.tgt_ready, (exp_q.size() < DEPTH));
            check("sr_illegal", (S && R), 0);
`ifndef SR_EXC_CHECK_EN
            check("err_off", err, 0);
            check("err_cnt_off", err_cnt, 0);
`endif
        end
    end

    typedef struct {
        bit       v;
        bit       b;
        bit       d;
        bit [1:0] sr;
        bit       sh;
        bit       ev;
    } vec_t;

    vec_t tbl[7];
    bit   pat9[9];
    bit   acc;
    int   pops0;

    task automatic drain();
        tif.tgt_valid = 1'b0;
        drive_en      = 1'b1;
        for (int g = 0; g < 40 && level != 0; g++) step();
        check("drain_empty", level, 0);
        step();
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0};
        pat9   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

        clear         = 1'b1;
        drive_en      = 1'b0;
        tif.tgt_valid = 1'b0;
        tif.tgt_bit   = 1'b0;
        step();
        step();
        check("rst_sr", {S, R}, 0);
        check("rst_level", level, 0);
        check("rst_ready", tif.tgt_ready, 1);
        check("rst_shadow", shadow_q, 0);
        check("rst_err", err, 0);
        #1 clear = 1'b0;

        // Clear in the middle of a stream, with S asserted and the FIFO non-empty.
        for (int i = 0; i < 3; i++) begin
            tif.tgt_valid = 1'b1;
            tif.tgt_bit   = (i != 1);
            step();
        end
        tif.tgt_valid = 1'b0;
        drive_en      = 1'b1;
        step();
        check("pre_clear_S", S, 1);
        check("pre_clear_level", level, 2);
        drive_en = 1'b0;
        @(posedge clk);
        #1 clear = 1'b1;
        #1;
        check("clr_S", S, 0);
        check("clr_R", R, 0);
        check("clr_exc", exc_valid, 0);
        check("clr_shadow", shadow_q, 0);
        check("clr_level", level, 0);
        check("clr_ready", tif.tgt_ready, 1);
        check("clr_err", err, 0);
        @(negedge clk);
        #2 clear = 1'b0;

        // Directed sequence 1,1,0,0,1 with drive enabled throughout.
        for (int i = 0; i < 7; i++) begin
            tif.tgt_valid = tbl[i].v;
            tif.tgt_bit   = tbl[i].b;
            drive_en      = tbl[i].d;
            step();
            check($sformatf("vec%0d_sr", i), {S, R}, tbl[i].sr);
            check($sformatf("vec%0d_shadow", i), shadow_q, tbl[i].sh);
            check($sformatf("vec%0d_exc", i), exc_valid, tbl[i].ev);
        end
        tif.tgt_valid = 1'b0;

        // Fill to full with drive held off, then hold a ninth target under back-pressure.
        drive_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tif.tgt_valid = 1'b1;
            tif.tgt_bit   = pat9[i];
            step();
        end
        check("full_level", level, 8);
        check("full_ready", tif.tgt_ready, 0);
        tif.tgt_bit = pat9[8];
        step();
        step();
        check("held_level", level, 8);
        pops0    = n_pops;
        drive_en = 1'b1;
        acc      = 1'b0;
        for (int g = 0; g < 20 && !acc; g++) begin
            acc = tif.tgt_ready;
            step();
        end
        check("ninth_accepted", acc, 1);
        drain();
        check("all_nine_emitted", n_pops - pops0, 9);

        // Simultaneous push and pop at level 3; pointers wrap past DEPTH.
        drive_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tif.tgt_valid = 1'b1;
            tif.tgt_bit   = (i != 1);
            step();
        end
        check("pp_start_level", level, 3);
        drive_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tif.tgt_valid = 1'b1;
            tif.tgt_bit   = (i % 3 == 0);
            step();
            check("pp_level", level, 3);
        end
        drain();

`ifdef SR_EXC_CHECK_EN
        check("chk_loop_err", err, 0);
        check("chk_loop_cnt", err_cnt, 0);
        inv = 1'b1;
        repeat (3) step();
        inv = 1'b0;
        check("chk_err_set", err, 1);
        check("chk_cnt3", err_cnt, 3);
        inv = 1'b1;
        repeat (2) step();
        inv = 1'b0;
        repeat (2) step();
        check("chk_cnt_sat", err_cnt, 3);
        check("chk_err_sticky", err, 1);
        @(posedge clk);
        #1 clear = 1'b1;
        #1;
        check("chk_clr_err", err, 0);
        check("chk_clr_cnt", err_cnt, 0);
        @(negedge clk);
        #2 clear = 1'b0;
`else
        repeat (10) step();
        check("nochk_err", err, 0);
        check("nochk_cnt", err_cnt, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
